lcd_delay_timer: RTL and testbench

// Parametrised delay timer for the LCD controller FSMs. Replaces the fixed-terminal

---
 rtl/lcd_delay_timer.sv | 149 ++++++++++++++
 tb/tb_lcd_delay_timer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_delay_timer.sv
// Shared wait-interval timer for the LCD controller sequencers: four selectable delays, one-shot or periodic.
// Optional LCD_TIMER_RETRIGGER_EN: restart on start while running, and an abort port that ends early with done.
module lcd_delay_timer #(
  parameter int CNT_W = 20,
  parameter int T0    = 750000,
  parameter int T1    = 205000,
  parameter int T2    = 82000,
  parameter int T3    = 2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             periodic,
  input  logic             stop,
`ifdef LCD_TIMER_RETRIGGER_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] clk_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] term_r, term_s;
  logic [1:0]       sel_r, sel_s;
  logic             per_r, per_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             abort_s;

  function automatic logic [CNT_W-1:0] term_of(input logic [1:0] s);
    logic [CNT_W-1:0] t;
    case (s)
      2'd0:    t = CNT_W'(T0);
      2'd1:    t = CNT_W'(T1);
      2'd2:    t = CNT_W'(T2);
      2'd3:    t = CNT_W'(T3);
      default: t = CNT_W'(T0);
    endcase
    return t;
  endfunction

  // The latched select must still describe the latched terminal; a mismatch means corrupted state.
  function automatic logic term_intact(input logic [1:0] s, input logic [CNT_W-1:0] t);
    return (term_of(s) == t);
  endfunction

`ifdef LCD_TIMER_RETRIGGER_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output decode; done is a single-cycle pulse by default.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    term_s  = term_r;
    sel_s   = sel_r;
    per_s   = per_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (start) begin
          sel_s   = sel;
          per_s   = periodic;
          term_s  = term_of(sel);
          busy_s  = 1'b1;
          state_s = ST_RUN;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop || !term_intact(sel_r, term_r)) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          cnt_s   = '0;
        end else if (abort_s) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          cnt_s   = '0;
          done_s  = 1'b1;
`ifdef LCD_TIMER_RETRIGGER_EN
        end else if (start) begin
          // Retrigger beats a coincident terminal count, so no done here.
          sel_s  = sel;
          per_s  = periodic;
          term_s = term_of(sel);
          cnt_s  = '0;
          busy_s = 1'b1;
`endif
        end else if (cnt_r == term_r) begin
          cnt_s  = '0;
          done_s = 1'b1;
          if (per_r) begin
            busy_s = 1'b1;
          end else begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s  = cnt_r + CNT_W'(1);
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      term_r  <= CNT_W'(T0);
      sel_r   <= 2'd0;
      per_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      term_r  <= term_s;
      sel_r   <= sel_s;
      per_r   <= per_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign clk_cnt = cnt_r;

endmodule

// File: tb/tb_lcd_delay_timer.sv
// Scoreboard bench for lcd_delay_timer with short terminal counts; expectations come from elapsed-edge arithmetic.
module tb_lcd_delay_timer;

  localparam int CW = 6;
  localparam int P0 = 40;
  localparam int P1 = 20;
  localparam int P2 = 9;
  localparam int P3 = 3;
`ifdef LCD_TIMER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic          periodic = 1'b0;
  logic          stop = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [CW-1:0] clk_cnt;

  always #5 clk = ~clk;

  lcd_delay_timer #(.CNT_W(CW), .T0(P0), .T1(P1), .T2(P2), .T3(P3)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .periodic(periodic), .stop(stop),
`ifdef LCD_TIMER_RETRIGGER_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .clk_cnt(clk_cnt)
  );

  typedef struct {int e; bit busy; int cnt;} exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: a running delay is described by the edge it began on, its length and mode.
  bit m_run = 1'b0;
  bit m_per = 1'b0;
  int m_start = 0;
  int m_term = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int tval(input logic [1:0] s);
    case (s)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  task automatic step(input bit rs, input bit st, input logic [1:0] sl, input bit pr,
                      input bit sp, input bit ab);
    int e, el, ec;
    bit eb, ed;
    @(negedge clk);
    reset = rs; start = st; sel = sl; periodic = pr; stop = sp; abort = ab;
    e = edge_n + 1; eb = 1'b0; ed = 1'b0; ec = 0;
    if (rs) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1; m_start = e; m_term = tval(sl); m_per = pr; eb = 1'b1;
      end
    end else begin
      el = (e - m_start) % (m_term + 1);
      if (sp) begin
        m_run = 1'b0;
      end else if (RETRIG && ab) begin
        m_run = 1'b0; ed = 1'b1;
      end else if (RETRIG && st) begin
        m_start = e; m_term = tval(sl); m_per = pr; eb = 1'b1;
      end else if (el == 0) begin
        ed = 1'b1; eb = m_per; m_run = m_per;
      end else begin
        eb = 1'b1; ec = el;
      end
    end
    exp_q.push_back('{e, eb, ec});
    if (ed) done_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares busy/clk_cnt every cycle and matches each done pulse against the expected edge.
  initial begin
    exp_t x;
    int   de;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
        x = exp_q.pop_front();
        checks++;
        if (busy !== x.busy) begin
          errors++;
          $display("FAIL busy edge=%0d got=%b want=%b", edge_n, busy, x.busy);
        end
        checks++;
        if (clk_cnt !== CW'(x.cnt)) begin
          errors++;
          $display("FAIL clk_cnt edge=%0d got=%0d want=%0d", edge_n, clk_cnt, x.cnt);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected edge=%0d got=1 want=0", edge_n);
        end else begin
          de = done_q.pop_front();
          if (de != edge_n) begin
            errors++;
            $display("FAIL done_edge got=%0d want=%0d", edge_n, de);
          end
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    // One-shot shortest delay.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(P3 + 3);
    // Periodic, three periods, then stop.
    step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    idle(3 * (P2 + 1) + 1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // Stop coinciding with the terminal count.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(P3);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Start while running.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(P0 + 5);
    // Reset mid-delay, then a normal delay.
    step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(P3 + 3);
    // Abort alone, then abort with stop.
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 10) == 0, 2'($urandom % 4),
           ($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0);
    end
    idle(P0 + 2);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing got=%0d pending want=0 (first edge %0d)", done_q.size(), done_q[0]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_drain got=%0d pending want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
